// File: rtl/sha256_arb_pkg.sv
// Shared types and constants for the SHA256 core arbiter.
// Used by sha256_arbiter, its picker and the requester-side interface.
package sha256_arb_pkg;

  localparam int NUM_REQ_MAX      = 8;
  localparam int DIGEST_WORDS_DEF = 16;
  localparam int BYTE_W           = 8;
  localparam int WORD_W           = 16;
  localparam int CNT_W            = 5;
  localparam int PTR_W            = $clog2(NUM_REQ_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FINISH,
    ST_DRAIN,
    ST_CLEAR
  } arb_state_e;

  // OR-reduction encoder: the input is one-hot, so no priority chain is needed.
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ_MAX-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sha256_arb_if.sv
// Requester-side bundle of the arbiter: byte streams in, grant and digest words out.
// master = requester group, slave = arbiter; the arbiter exposes the same signals as flat ports.
interface sha256_arb_if
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_last;
  logic [WORD_W-1:0]         resp_data;
  logic                      digest_err;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, grant, resp_valid, resp_last, resp_data, digest_err
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, grant, resp_valid, resp_last, resp_data, digest_err
  );

endinterface

// File: rtl/sha256_arb_picker.sv
// Combinational one-hot winner selection for the core arbiter.
// SHA_ARB_FIXED_PRIO_EN: lowest asserted index wins and no pointer input exists.
module sha256_arb_picker
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef SHA_ARB_FIXED_PRIO_EN
  input  logic [PTR_W-1:0]   ptr_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef SHA_ARB_FIXED_PRIO_EN

  assign gnt_o = req_i & (~req_i + NUM_REQ'(1));

`else

  // Rotate so the index after the previous owner sits at bit 0, isolate the
  // lowest set bit, then rotate back. A shift of NUM_REQ wraps to no rotation.
  logic [PTR_W:0]          start;
  logic [2*NUM_REQ-1:0]    req_dbl;
  logic [2*NUM_REQ-1:0]    req_shr;
  logic [NUM_REQ-1:0]      rot;
  logic [NUM_REQ-1:0]      rot_gnt;
  logic [2*NUM_REQ-1:0]    gnt_dbl;

  assign start   = {1'b0, ptr_i} + (PTR_W+1)'(1);
  assign req_dbl = {req_i, req_i};
  assign req_shr = req_dbl >> start;
  assign rot     = req_shr[NUM_REQ-1:0];
  assign rot_gnt = rot & (~rot + NUM_REQ'(1));
  assign gnt_dbl = {rot_gnt, rot_gnt} << start;
  assign gnt_o   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];

`endif

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one SHA256 core between NUM_REQ byte-stream requesters; all outputs registered.
// Define SHA_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sha256_arbiter
  import sha256_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DIGEST_WORDS = DIGEST_WORDS_DEF
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [NUM_REQ-1:0]        resp_last,
  output logic [WORD_W-1:0]         resp_data,
  output logic                      digest_err,
  output logic                      core_reset,
  output logic                      core_load_enable,
  output logic                      core_input_complete,
  output logic [BYTE_W-1:0]         core_input_data,
  input  logic [WORD_W-1:0]         core_hashed_data,
  input  logic                      core_read_enable,
  input  logic                      core_done
);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [NUM_REQ-1:0]  resp_last_q;
  logic [WORD_W-1:0]   resp_data_q;
  logic                digest_err_q;
  logic                core_reset_q;
  logic                core_load_enable_q;
  logic                core_input_complete_q;
  logic [BYTE_W-1:0]   core_input_data_q;
  logic [CNT_W-1:0]    cnt_q;
`ifndef SHA_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]    ptr_q;
`endif

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [BYTE_W-1:0]   owner_byte;
  logic                owner_last;
  logic                byte_acc;
  logic [CNT_W:0]      words_at_done;

  sha256_arb_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i (req_valid),
`ifndef SHA_ARB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (pick_gnt)
  );

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    owner_byte = '0;
    owner_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_byte = owner_byte | req_data[BYTE_W*i +: BYTE_W];
        owner_last = owner_last | req_last[i];
      end
    end
  end

  assign byte_acc      = |(req_valid & req_ready_q);
  assign words_at_done = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q               <= ST_IDLE;
      grant_q               <= '0;
      req_ready_q           <= '0;
      resp_valid_q          <= '0;
      resp_last_q           <= '0;
      resp_data_q           <= '0;
      digest_err_q          <= 1'b0;
      core_reset_q          <= 1'b1;
      core_load_enable_q    <= 1'b0;
      core_input_complete_q <= 1'b0;
      core_input_data_q     <= '0;
      cnt_q                 <= '0;
`ifndef SHA_ARB_FIXED_PRIO_EN
      ptr_q                 <= '0;
`endif
    end else begin
      core_load_enable_q <= 1'b0;
      resp_valid_q       <= '0;
      resp_last_q        <= '0;
      digest_err_q       <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          core_reset_q <= 1'b0;
          if (|req_valid) begin
            grant_q     <= pick_gnt;
            req_ready_q <= pick_gnt;
            state_q     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (byte_acc) begin
            core_load_enable_q <= 1'b1;
            core_input_data_q  <= owner_byte;
            if (owner_last) begin
              req_ready_q <= '0;
              state_q     <= ST_FINISH;
            end
          end
        end

        ST_FINISH: begin
          core_input_complete_q <= 1'b1;
          state_q               <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (core_done) begin
            resp_valid_q          <= grant_q;
            resp_last_q           <= grant_q;
            resp_data_q           <= core_hashed_data;
            digest_err_q          <= (words_at_done != (CNT_W+1)'(DIGEST_WORDS));
            core_input_complete_q <= 1'b0;
            core_reset_q          <= 1'b1;
            state_q               <= ST_CLEAR;
          end else if (core_read_enable) begin
            resp_valid_q <= grant_q;
            resp_data_q  <= core_hashed_data;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_CLEAR: begin
          core_reset_q <= 1'b0;
          cnt_q        <= '0;
`ifndef SHA_ARB_FIXED_PRIO_EN
          ptr_q        <= onehot_to_idx(NUM_REQ_MAX'(grant_q));
`endif
          grant_q      <= '0;
          state_q      <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready           = req_ready_q;
  assign grant               = grant_q;
  assign resp_valid          = resp_valid_q;
  assign resp_last           = resp_last_q;
  assign resp_data           = resp_data_q;
  assign digest_err          = digest_err_q;
  assign core_reset          = core_reset_q;
  assign core_load_enable    = core_load_enable_q;
  assign core_input_complete = core_input_complete_q;
  assign core_input_data     = core_input_data_q;

endmodule
